// File: rtl/rdma_ack_tracker.sv
// RDMA ACK tracker: gates SQ issue on per-PID and global outstanding limits, and turns
// matched ACK/NAK metadata into a registered completion stream.
module rdma_ack_tracker #(
  parameter int unsigned N_PID           = 64,
  parameter int unsigned MAX_OUTSTANDING = 32,
  parameter int unsigned MSN_BITS        = 24,
  parameter int unsigned SNDRM_BITS      = 8,
  localparam int unsigned PID_BITS       = (N_PID > 1) ? $clog2(N_PID) : 1
) (
  input  logic                  nclk,
  input  logic                  nresetn,
  input  logic                  s_sq_valid,
  output logic                  s_sq_ready,
  input  logic [PID_BITS-1:0]   s_sq_pid,
  output logic                  m_sq_valid,
  input  logic                  m_sq_ready,
  input  logic                  s_ack_valid,
  output logic                  s_ack_ready,
  input  logic                  s_ack_is_nak,
  input  logic [PID_BITS-1:0]   s_ack_pid,
  input  logic [SNDRM_BITS-1:0] s_ack_syndrome,
  input  logic [MSN_BITS-1:0]   s_ack_msn,
  output logic                  m_cq_valid,
  input  logic                  m_cq_ready,
  output logic [PID_BITS-1:0]   m_cq_pid,
  output logic                  m_cq_is_nak,
  output logic [SNDRM_BITS-1:0] m_cq_syndrome,
  output logic [MSN_BITS-1:0]   m_cq_msn,
  output logic [15:0]           outstanding_total,
  output logic [31:0]           nak_count,
  output logic [31:0]           stray_ack_count
);

  logic [7:0]            cnt_q [N_PID];
  logic [7:0]            cnt_d [N_PID];
  logic [15:0]           total_q, total_d;
  logic [31:0]           nak_q, nak_d;
  logic [31:0]           stray_q, stray_d;
  logic                  cq_valid_q, cq_valid_d;
  logic [PID_BITS-1:0]   cq_pid_q, cq_pid_d;
  logic                  cq_nak_q, cq_nak_d;
  logic [SNDRM_BITS-1:0] cq_syn_q, cq_syn_d;
  logic [MSN_BITS-1:0]   cq_msn_q, cq_msn_d;

  logic sq_ok, sq_fire, ack_acc, ack_stray, ack_hit;

  always_comb begin
    sq_ok       = (32'(total_q) < MAX_OUTSTANDING) && (cnt_q[s_sq_pid] != 8'hFF);
    m_sq_valid  = s_sq_valid & sq_ok;
    s_sq_ready  = m_sq_ready & sq_ok;
    sq_fire     = m_sq_valid & m_sq_ready;
    s_ack_ready = ~cq_valid_q | m_cq_ready;
    ack_acc     = s_ack_valid & s_ack_ready;
    // Stray check uses the pre-update count, even if an SQ for this PID fires now.
    ack_stray   = (cnt_q[s_ack_pid] == 8'd0);
    ack_hit     = ack_acc & ~ack_stray;
  end

  always_comb begin
    cnt_d      = cnt_q;
    total_d    = total_q;
    nak_d      = nak_q;
    stray_d    = stray_q;
    cq_valid_d = cq_valid_q;
    cq_pid_d   = cq_pid_q;
    cq_nak_d   = cq_nak_q;
    cq_syn_d   = cq_syn_q;
    cq_msn_d   = cq_msn_q;

    // Applied in sequence so a same-PID fire and hit net to zero.
    if (sq_fire) begin
      cnt_d[s_sq_pid] = cnt_q[s_sq_pid] + 8'd1;
      total_d         = total_d + 16'd1;
    end
    if (ack_hit) begin
      cnt_d[s_ack_pid] = cnt_d[s_ack_pid] - 8'd1;
      total_d          = total_d - 16'd1;
      if (s_ack_is_nak && (nak_q != 32'hFFFF_FFFF)) nak_d = nak_q + 32'd1;
    end
    if (ack_acc && ack_stray && (stray_q != 32'hFFFF_FFFF)) stray_d = stray_q + 32'd1;

    if (ack_hit) begin
      cq_valid_d = 1'b1;
      cq_pid_d   = s_ack_pid;
      cq_nak_d   = s_ack_is_nak;
      cq_syn_d   = s_ack_syndrome;
      cq_msn_d   = s_ack_msn;
    end else if (m_cq_ready) begin
      cq_valid_d = 1'b0;
    end
  end

  always_ff @(posedge nclk) begin
    if (!nresetn) begin
      for (int i = 0; i < int'(N_PID); i++) cnt_q[i] <= 8'd0;
      total_q    <= '0;
      nak_q      <= '0;
      stray_q    <= '0;
      cq_valid_q <= 1'b0;
      cq_pid_q   <= '0;
      cq_nak_q   <= 1'b0;
      cq_syn_q   <= '0;
      cq_msn_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      nak_q      <= nak_d;
      stray_q    <= stray_d;
      cq_valid_q <= cq_valid_d;
      cq_pid_q   <= cq_pid_d;
      cq_nak_q   <= cq_nak_d;
      cq_syn_q   <= cq_syn_d;
      cq_msn_q   <= cq_msn_d;
    end
  end

  assign m_cq_valid        = cq_valid_q;
  assign m_cq_pid          = cq_pid_q;
  assign m_cq_is_nak       = cq_nak_q;
  assign m_cq_syndrome     = cq_syn_q;
  assign m_cq_msn          = cq_msn_q;
  assign outstanding_total = total_q;
  assign nak_count         = nak_q;
  assign stray_ack_count   = stray_q;

endmodule
